// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants for the seven-segment bus receiver:
//               active-low segment patterns {a,b,c,d,e,f,g}, active-low digit
//               position codes and the frame-capture FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Active-low segment patterns, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low digit enables
    localparam logic [3:0] AN_UNITS     = 4'b1110;
    localparam logic [3:0] AN_TENS      = 4'b1101;
    localparam logic [3:0] AN_HUNDREDS  = 4'b1011;
    localparam logic [3:0] AN_THOUSANDS = 4'b0111;

    // Frame-capture FSM
    typedef enum logic [2:0] {
        ST_HUNT   = 3'd0,
        ST_CAP1   = 3'd1,
        ST_CAP2   = 3'd2,
        ST_CAP3   = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_digit_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_digit_decode
// Description : Combinational decode of an active-low seven-segment pattern
//               back to a BCD digit; ok is low for any non-digit pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       ok
);

    // Pattern lookup; anything outside the ten digit glyphs is rejected
    always_comb begin
        bcd = 4'd0;
        ok  = 1'b1;
        case (seg)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: ok  = 1'b0;
            default:   ok  = 1'b0;
        endcase
    end

endmodule : seg7_digit_decode
`default_nettype wire

// File: rtl/seg_7_4_rx.sv
`default_nettype none
// ============================================================================
// Module      : seg_7_4_rx
// Description : Samples a multiplexed 4-digit seven-segment bus, debounces
//               each digit dwell, reassembles a units..thousands scan frame
//               and publishes the 10-bit binary value it represents.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_7_4_rx
    import seg7_pkg::*;
#(
    parameter int STABLE_CNT = 4,
    parameter int TIMEOUT    = 255,
    parameter int CNT_W      = 8
) (
    input  logic        clk_sample,
    input  logic        rst_n,
    input  logic [3:0]  an_n,
    input  logic [6:0]  seg,
    output logic [9:0]  value,
    output logic        value_valid,
    output logic [15:0] digits,
    output logic        frame_err
);

    localparam logic [CNT_W-1:0] STABLE_M1 = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    // True when exactly one digit enable is asserted (low)
    function automatic logic is_one_cold(input logic [3:0] a);
        case (a)
            AN_UNITS, AN_TENS, AN_HUNDREDS, AN_THOUSANDS: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

    // Position expected next while capturing a frame
    function automatic logic [3:0] expected_pos(input state_t s);
        case (s)
            ST_CAP1: return AN_TENS;
            ST_CAP2: return AN_HUNDREDS;
            default: return AN_THOUSANDS;
        endcase
    endfunction

    // th*1000 + hu*100 + te*10 + un built from shifted partial products
    function automatic logic [13:0] weighted_sum(input logic [3:0] th,
                                                 input logic [3:0] hu,
                                                 input logic [3:0] te,
                                                 input logic [3:0] un);
        logic [13:0] t, h, e, u;
        t = {10'd0, th};
        h = {10'd0, hu};
        e = {10'd0, te};
        u = {10'd0, un};
        return (t << 9) + (t << 8) + (t << 7) + (t << 6) + (t << 5) + (t << 3)
             + (h << 6) + (h << 5) + (h << 2)
             + (e << 3) + (e << 1)
             + u;
    endfunction

    logic [3:0]       an_meta, an_sync, an_prev;
    logic [6:0]       seg_meta, seg_sync, seg_prev;
    logic [CNT_W-1:0] stab_cnt, stab_next;
    logic [CNT_W-1:0] tmo_cnt;
    logic             armed;
    logic             bus_same, an_changed, accept;
    logic [3:0]       dec_bcd;
    logic             dec_ok;
    state_t           state, next_state;
    logic             err;
    logic             ld_un, ld_te, ld_hu, ld_th;
    logic [3:0]       dig_un, dig_te, dig_hu, dig_th;
    logic [13:0]      sum;

    seg7_digit_decode u_decode (
        .seg (seg_sync),
        .bcd (dec_bcd),
        .ok  (dec_ok)
    );

    // Two-flop synchroniser plus the previous-sample copy for change detection
    always_ff @(posedge clk_sample or negedge rst_n) begin
        if (!rst_n) begin
            an_meta  <= 4'b1111;
            an_sync  <= 4'b1111;
            an_prev  <= 4'b1111;
            seg_meta <= SEG_BLANK;
            seg_sync <= SEG_BLANK;
            seg_prev <= SEG_BLANK;
        end else begin
            an_meta  <= an_n;
            an_sync  <= an_meta;
            an_prev  <= an_sync;
            seg_meta <= seg;
            seg_sync <= seg_meta;
            seg_prev <= seg_sync;
        end
    end

    // Stability count and single-shot acceptance per an_n dwell
    always_comb begin
        bus_same   = ({an_sync, seg_sync} == {an_prev, seg_prev});
        an_changed = (an_sync != an_prev);
        stab_next  = '0;
        if (bus_same) begin
            stab_next = (stab_cnt == CNT_MAX) ? stab_cnt : stab_cnt + 1'b1;
        end
        accept = (stab_next == STABLE_M1) && is_one_cold(an_sync)
               && (armed || an_changed);
    end

    // Stability counter and re-arm flag (re-armed only by an an_n change)
    always_ff @(posedge clk_sample or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt <= '0;
            armed    <= 1'b1;
        end else begin
            stab_cnt <= stab_next;
            if (accept)
                armed <= 1'b0;
            else if (an_changed)
                armed <= 1'b1;
        end
    end

    // Inter-digit timeout, running only while a frame is being captured
    always_ff @(posedge clk_sample or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == ST_HUNT || state == ST_COMMIT || accept) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != CNT_MAX) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk_sample or negedge rst_n) begin
        if (!rst_n)
            state <= ST_HUNT;
        else
            state <= next_state;
    end

    // Next-state, digit-latch enables and frame error detection
    always_comb begin
        next_state = state;
        err        = 1'b0;
        ld_un      = 1'b0;
        ld_te      = 1'b0;
        ld_hu      = 1'b0;
        ld_th      = 1'b0;
        case (state)
            ST_HUNT: begin
                if (accept && an_sync == AN_UNITS && dec_ok) begin
                    ld_un      = 1'b1;
                    next_state = ST_CAP1;
                end
            end
            ST_CAP1, ST_CAP2, ST_CAP3: begin
                if (accept) begin
                    if (an_sync == expected_pos(state) && dec_ok) begin
                        case (state)
                            ST_CAP1: begin ld_te = 1'b1; next_state = ST_CAP2;   end
                            ST_CAP2: begin ld_hu = 1'b1; next_state = ST_CAP3;   end
                            default: begin ld_th = 1'b1; next_state = ST_COMMIT; end
                        endcase
                    end else if (an_sync == AN_UNITS && dec_ok) begin
                        // A fresh units digit restarts the frame immediately
                        err        = 1'b1;
                        ld_un      = 1'b1;
                        next_state = ST_CAP1;
                    end else begin
                        err        = 1'b1;
                        next_state = ST_HUNT;
                    end
                end else if (tmo_cnt == TMO_LIMIT) begin
                    err        = 1'b1;
                    next_state = ST_HUNT;
                end
            end
            ST_COMMIT: next_state = ST_HUNT;
            default:   next_state = ST_HUNT;
        endcase
    end

    // Latched BCD digits of the frame in progress
    always_ff @(posedge clk_sample or negedge rst_n) begin
        if (!rst_n) begin
            dig_un <= 4'd0;
            dig_te <= 4'd0;
            dig_hu <= 4'd0;
            dig_th <= 4'd0;
        end else begin
            if (ld_un) dig_un <= dec_bcd;
            if (ld_te) dig_te <= dec_bcd;
            if (ld_hu) dig_hu <= dec_bcd;
            if (ld_th) dig_th <= dec_bcd;
        end
    end

    assign sum = weighted_sum(dig_th, dig_hu, dig_te, dig_un);

    // Registered outputs: publish in-range frames, flag everything else
    always_ff @(posedge clk_sample or negedge rst_n) begin
        if (!rst_n) begin
            value       <= 10'd0;
            digits      <= 16'd0;
            value_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            frame_err   <= err;
            if (state == ST_COMMIT) begin
                if (sum[13:10] == 4'd0) begin
                    value       <= sum[9:0];
                    digits      <= {dig_th, dig_hu, dig_te, dig_un};
                    value_valid <= 1'b1;
                end else begin
                    frame_err   <= 1'b1;
                end
            end
        end
    end

endmodule : seg_7_4_rx
`default_nettype wire

// File: tb/tb_seg_7_4_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_7_4_rx
// Description : Directed bench for seg_7_4_rx: a table of whole scan frames
//               with hand-computed results, followed by hand-written
//               sequences for ordering, glitch, timeout and reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_7_4_rx;

    logic        clk_sample = 1'b0;
    logic        rst_n;
    logic [3:0]  an_n;
    logic [6:0]  seg;
    logic [9:0]  value;
    logic        value_valid;
    logic [15:0] digits;
    logic        frame_err;

    int n_vec = 0;
    int n_bad = 0;
    int n_vv  = 0;
    int n_fe  = 0;
    int n_ovl = 0;

    logic [6:0] lut [10];

    typedef struct {
        logic [3:0]  th, hu, te, un;
        logic [9:0]  exp_value;
        logic [15:0] exp_digits;
        int          exp_vv;
        int          exp_fe;
    } frame_vec_t;

    frame_vec_t vecs [8];

    seg_7_4_rx #(.STABLE_CNT(4), .TIMEOUT(255), .CNT_W(8)) dut (
        .clk_sample  (clk_sample),
        .rst_n       (rst_n),
        .an_n        (an_n),
        .seg         (seg),
        .value       (value),
        .value_valid (value_valid),
        .digits      (digits),
        .frame_err   (frame_err)
    );

    always #5 clk_sample = ~clk_sample;

    // Pulse counters sampled on the falling edge
    always @(negedge clk_sample) begin
        if (rst_n) begin
            if (value_valid) n_vv++;
            if (frame_err) n_fe++;
            if (value_valid && frame_err) n_ovl++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an_n = a;
        seg  = s;
        repeat (n) @(posedge clk_sample);
        #1;
    endtask

    task automatic idle(input int n);
        hold(4'b1111, 7'b1111111, n);
    endtask

    task automatic run_frame(input logic [3:0] th, input logic [3:0] hu,
                             input logic [3:0] te, input logic [3:0] un);
        hold(4'b1110, lut[un], 10);
        hold(4'b1101, lut[te], 10);
        hold(4'b1011, lut[hu], 10);
        hold(4'b0111, lut[th], 10);
        idle(8);
    endtask

    initial begin
        int vv0, fe0, lat;
        bit seen;

        lut[0] = 7'b0000001; lut[1] = 7'b1001111; lut[2] = 7'b0010010;
        lut[3] = 7'b0000110; lut[4] = 7'b1001100; lut[5] = 7'b0100100;
        lut[6] = 7'b0100000; lut[7] = 7'b0001111; lut[8] = 7'b0000000;
        lut[9] = 7'b0000100;

        vecs[0] = '{4'd1, 4'd0, 4'd2, 4'd3, 10'd1023, 16'h1023, 1, 0};
        vecs[1] = '{4'd0, 4'd0, 4'd4, 4'd2, 10'd42,   16'h0042, 1, 0};
        vecs[2] = '{4'd1, 4'd0, 4'd2, 4'd4, 10'd42,   16'h0042, 0, 1};
        vecs[3] = '{4'd0, 4'd9, 4'd8, 4'd7, 10'd987,  16'h0987, 1, 0};
        vecs[4] = '{4'd0, 4'd7, 4'd6, 4'd5, 10'd765,  16'h0765, 1, 0};
        vecs[5] = '{4'd9, 4'd9, 4'd9, 4'd9, 10'd765,  16'h0765, 0, 1};
        vecs[6] = '{4'd0, 4'd0, 4'd0, 4'd0, 10'd0,    16'h0000, 1, 0};
        vecs[7] = '{4'd0, 4'd3, 4'd1, 4'd6, 10'd316,  16'h0316, 1, 0};

        // Reset state
        rst_n = 1'b0;
        an_n  = 4'b1111;
        seg   = 7'b1111111;
        repeat (3) @(posedge clk_sample);
        #1;
        check("reset_value", int'(value), 0);
        check("reset_digits", int'(digits), 0);
        check("reset_valid", int'(value_valid), 0);
        check("reset_err", int'(frame_err), 0);
        rst_n = 1'b1;
        idle(5);

        // Table of complete frames
        for (int i = 0; i < 8; i++) begin
            vv0 = n_vv;
            fe0 = n_fe;
            run_frame(vecs[i].th, vecs[i].hu, vecs[i].te, vecs[i].un);
            check($sformatf("frame%0d_value", i), int'(value), int'(vecs[i].exp_value));
            check($sformatf("frame%0d_digits", i), int'(digits), int'(vecs[i].exp_digits));
            check($sformatf("frame%0d_valid_pulses", i), n_vv - vv0, vecs[i].exp_vv);
            check($sformatf("frame%0d_err_pulses", i), n_fe - fe0, vecs[i].exp_fe);
        end

        // Out of order: units then hundreds, followed by a clean 0042 frame
        vv0 = n_vv; fe0 = n_fe;
        hold(4'b1110, lut[5], 10);
        hold(4'b1011, lut[1], 10);
        idle(8);
        check("order_err_pulses", n_fe - fe0, 1);
        check("order_valid_pulses", n_vv - vv0, 0);
        check("order_value_kept", int'(value), 316);
        vv0 = n_vv; fe0 = n_fe;
        run_frame(4'd0, 4'd0, 4'd4, 4'd2);
        check("after_order_value", int'(value), 42);
        check("after_order_pulses", (n_vv - vv0) * 16 + (n_fe - fe0), 16);

        // Glitching segments on units, then a steady 1; rest of frame zeros
        vv0 = n_vv; fe0 = n_fe;
        for (int k = 0; k < 3; k++) begin
            hold(4'b1110, lut[1], 2);
            hold(4'b1110, lut[2], 2);
        end
        hold(4'b1110, lut[1], 10);
        hold(4'b1101, lut[0], 10);
        hold(4'b1011, lut[0], 10);
        hold(4'b0111, lut[0], 10);
        idle(8);
        check("glitch_value", int'(value), 1);
        check("glitch_digits", int'(digits), 16'h0001);
        check("glitch_valid_pulses", n_vv - vv0, 1);
        check("glitch_err_pulses", n_fe - fe0, 0);

        // Blank glyph in the tens slot
        vv0 = n_vv; fe0 = n_fe;
        hold(4'b1110, lut[4], 10);
        hold(4'b1101, 7'b1111111, 10);
        idle(8);
        check("blank_err_pulses", n_fe - fe0, 1);
        check("blank_valid_pulses", n_vv - vv0, 0);
        check("blank_value_kept", int'(value), 1);

        // Timeout: units 7 accepted, then the bus goes idle
        hold(4'b1110, lut[7], 10);
        an_n = 4'b1111;
        seg  = 7'b1111111;
        lat  = 0;
        seen = 1'b0;
        while (lat < 300 && !seen) begin
            @(posedge clk_sample);
            #1;
            lat++;
            if (frame_err) seen = 1'b1;
        end
        check("timeout_err_seen", int'(seen), 1);
        n_vec++;
        if (!(lat >= 245 && lat <= 260)) begin
            n_bad++;
            $display("FAIL timeout_latency: got %0d cycles, required 245..260", lat);
        end
        check("timeout_value_kept", int'(value), 1);
        idle(5);

        // Reset in the middle of a frame
        hold(4'b1110, lut[8], 10);
        hold(4'b1101, lut[3], 10);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_value", int'(value), 0);
        check("midreset_digits", int'(digits), 0);
        check("midreset_pulses", int'(value_valid) + int'(frame_err), 0);
        idle(4);
        vv0 = n_vv; fe0 = n_fe;
        rst_n = 1'b1;
        idle(10);
        check("post_reset_no_pulses", (n_vv - vv0) + (n_fe - fe0), 0);
        vv0 = n_vv; fe0 = n_fe;
        run_frame(4'd0, 4'd5, 4'd1, 4'd2);
        check("post_reset_value", int'(value), 512);
        check("post_reset_digits", int'(digits), 16'h0512);
        check("post_reset_pulses", (n_vv - vv0) * 16 + (n_fe - fe0), 16);

        check("valid_err_overlap", n_ovl, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_seg_7_4_rx
`default_nettype wire
